// File: rtl/wb_write_queue.sv
// wb_write_queue
//   In-order write-back queue in front of the register file's single write
//   port. Results are accepted over a valid/ready handshake, buffered in a
//   DEPTH-entry circular buffer and drained one per cycle onto regwr/rw/busw.
//   Writes to register 0 complete the handshake but are never stored.
//
//   Optional feature macro: WBQ_BYPASS_EN
//     defined   -> rs/rt lookup searches occupied entries; youngest match wins
//     undefined -> no search logic; rs_hit/rt_hit/rs_val/rt_val tied to 0
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   producer handshake; in_ready = !full
//   in_rd, in_data      destination index and value of the offered result
//   wr_hold             register-file write port unavailable; no drain
//   regwr, rw, busw     register-file write port, driven from the head entry
//   level               number of occupied entries
//   rs_q, rt_q          operand indices to look up
//   rs_hit/rs_val,
//   rt_hit/rt_val       lookup result (value of the youngest matching entry)
//
// Handshake: a transfer happens at a rising edge where in_valid && in_ready.
// in_ready depends only on the registered occupancy, never on in_valid, and
// the producer must hold its offer stable until it sees the transfer.

module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [DW-1:0]              in_data,
  input  logic                       wr_hold,
  output logic                       regwr,
  output logic [AW-1:0]              rw,
  output logic [DW-1:0]              busw,
  output logic [$clog2(DEPTH):0]     level,
  input  logic [AW-1:0]              rs_q,
  input  logic [AW-1:0]              rt_q,
  output logic                       rs_hit,
  output logic                       rt_hit,
  output logic [DW-1:0]              rs_val,
  output logic [DW-1:0]              rt_val
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  // Pointers and count carry one extra bit so full and empty never alias.
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   count;

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  // Register 0 is the hard-wired zero: accept the transfer, store nothing.
  assign push     = accept && (in_rd != '0);
  assign pop      = regwr;

  assign regwr = !empty && !wr_hold;
  assign rw    = empty ? '0 : rd_mem[rd_ptr[PW-1:0]];
  assign busw  = empty ? '0 : data_mem[rd_ptr[PW-1:0]];
  assign level = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr[PW-1:0]]   <= in_rd;
      data_mem[wr_ptr[PW-1:0]] <= in_data;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [PW-1:0] rs_idx;
  logic [PW-1:0] rt_idx;

  // Walk from oldest (head) to youngest; a later match overrides an earlier
  // one, so the entry nearest the write pointer supplies the value.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_val = '0;
    rt_val = '0;
    rs_idx = '0;
    rt_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_idx = rd_ptr[PW-1:0] + PW'(i);
      rt_idx = rd_ptr[PW-1:0] + PW'(i);
      if (((PW+1)'(i) < count) && (rs_q != '0) && (rd_mem[rs_idx] == rs_q)) begin
        rs_hit = 1'b1;
        rs_val = data_mem[rs_idx];
      end
      if (((PW+1)'(i) < count) && (rt_q != '0) && (rd_mem[rt_idx] == rt_q)) begin
        rt_hit = 1'b1;
        rt_val = data_mem[rt_idx];
      end
    end
  end

  logic ptr_msb_unused;
  assign ptr_msb_unused = wr_ptr[PW] ^ rd_ptr[PW];
`else
  assign rs_hit = 1'b0;
  assign rt_hit = 1'b0;
  assign rs_val = '0;
  assign rt_val = '0;

  logic lookup_unused;
  assign lookup_unused = (^rs_q) ^ (^rt_q) ^ wr_ptr[PW] ^ rd_ptr[PW];
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Testbench for wb_write_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the write-back queue.

module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef WBQ_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          wr_hold;
  logic          regwr;
  logic [AW-1:0] rw;
  logic [DW-1:0] busw;
  logic [LW-1:0] level;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic          rs_hit;
  logic          rt_hit;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;

  int total = 0;
  int bad   = 0;
  int writes_seen = 0;

  // Reference model: pending writes in acceptance order, {rd, data}.
  logic [AW+DW-1:0] exp_q[$];

  wb_write_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wr_hold(wr_hold),
    .regwr(regwr), .rw(rw), .busw(busw), .level(level),
    .rs_q(rs_q), .rt_q(rt_q),
    .rs_hit(rs_hit), .rt_hit(rt_hit), .rs_val(rs_val), .rt_val(rt_val)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Youngest queued entry for index idx, as {hit, value}.
  function automatic logic [DW:0] model_lookup(input logic [AW-1:0] idx);
    if (!BYPASS_ON || idx == '0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][AW+DW-1:DW] == idx) return {1'b1, exp_q[i][DW-1:0]};
    return '0;
  endfunction

  task automatic check_outputs();
    logic [DW:0] rs_e;
    logic [DW:0] rt_e;
    logic        exp_regwr;
    exp_regwr = (exp_q.size() != 0) && !wr_hold;
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check("level",    64'(level),    64'(exp_q.size()));
    check("regwr",    64'(regwr),    64'(exp_regwr));
    check("rw",   64'(rw),   (exp_q.size() != 0) ? 64'(exp_q[0][AW+DW-1:DW]) : 64'd0);
    check("busw", 64'(busw), (exp_q.size() != 0) ? 64'(exp_q[0][DW-1:0])     : 64'd0);
    rs_e = model_lookup(rs_q);
    rt_e = model_lookup(rt_q);
    check("rs_hit", 64'(rs_hit), 64'(rs_e[DW]));
    check("rs_val", 64'(rs_val), 64'(rs_e[DW-1:0]));
    check("rt_hit", 64'(rt_hit), 64'(rt_e[DW]));
    check("rt_val", 64'(rt_val), 64'(rt_e[DW-1:0]));
  endtask

  // ---------------- driver ----------------
  // One cycle: drive on the falling edge, check, then advance the model at
  // the rising edge using the rules of the queue.
  task automatic step(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                      input logic h, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    bit was_full;
    bit do_pop;
    @(negedge clk);
    in_valid = v; in_rd = rd; in_data = d; wr_hold = h; rs_q = rs; rt_q = rt;
    #1;
    check_outputs();
    was_full = (exp_q.size() == DEPTH);
    do_pop   = (exp_q.size() != 0) && !h;
    @(posedge clk);
    if (do_pop) begin
      void'(exp_q.pop_front());
      writes_seen++;
    end
    if (v && !was_full && rd != '0) exp_q.push_back({rd, d});
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, h, '0, '0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    @(negedge clk);
    in_valid = 1'b0; wr_hold = 1'b0; rs_q = '0; rt_q = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_regwr", 64'(regwr), 64'd0);
    check("rst_rw",    64'(rw),    64'd0);
    check("rst_busw",  64'(busw),  64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    #1 reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int w0;
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; wr_hold = 1'b0;
    rs_q = '0; rt_q = '0;
    #22 reset = 1'b0;

    // reset state
    idle(1, 1'b0);

    // single write into an empty queue: level 0 -> 1 -> 0
    step(1'b1, 5'd8, 32'h0000_00AA, 1'b0, 5'd8, '0);
    step(1'b0, '0, '0, 1'b0, 5'd8, '0);
    idle(1, 1'b0);

    // register 0 is absorbed
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0);
    idle(2, 1'b0);

    // fill with the port held, offer one more while full, then drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, AW'(i), 32'h100 + DW'(i), 1'b1, AW'(i), 5'd3);
    step(1'b1, 5'd9, 32'hBAD0_0009, 1'b1, 5'd9, 5'd4);
    w0 = writes_seen;
    idle(DEPTH + 1, 1'b0);
    check("fill_drain_cnt", 64'(writes_seen - w0), 64'(DEPTH));

    // bypass: youngest of two matches wins, index 0 never hits
    step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 5'd0);
    step(1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 5'd0);
    step(1'b0, '0, '0, 1'b1, 5'd5, 5'd0);
    check("byp_hit_direct", 64'(rs_hit), 64'(BYPASS_ON));
    check("byp_val_direct", 64'(rs_val), BYPASS_ON ? 64'h22 : 64'h0);
    idle(3, 1'b0);

    // back-to-back stream through the wrap point
    w0 = writes_seen;
    for (int i = 1; i <= 10; i++) step(1'b1, AW'(i), 32'hC000 + DW'(i), 1'b0, AW'(i), AW'(i-1));
    idle(2, 1'b0);
    check("stream_cnt", 64'(writes_seen - w0), 64'd10);

    // reset with three entries queued; nothing drains afterwards
    for (int i = 1; i <= 3; i++) step(1'b1, AW'(i+20), 32'hE0 + DW'(i), 1'b1, '0, '0);
    reset_pulse();
    idle(3, 1'b0);

    // random traffic over a small index range to force aliasing and lookups
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      if ($urandom_range(0, 199) == 0) reset_pulse();
    end
    idle(DEPTH + 1, 1'b0);
    check("final_empty", 64'(level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
